// File: rtl/dice_roll_ctrl.sv
// ---------------------------------------------------------------------------
// dice_roll_ctrl
//   Dice-roll sequencer in front of the "dN" seven-segment display block.
//   A rising edge on roll starts a roll. The block draws an unbiased value
//   1..F from a free-running 16-bit LFSR by masked rejection sampling. It
//   converts the value to BCD with a sequential double-dabble. It then commits
//   the binary result, the three BCD digits and the leading-zero enables in
//   a single cycle.
//
// Ports
//   clk     in   1  system clock, rising edge
//   reset   in   1  synchronous active-high reset
//   roll    in   1  roll request level (debounced, synchronised)
//   faces   in   7  die face count, clamped to 2..100 when a roll starts
//   bcd100  out  4  hundreds digit of last result
//   bcd10   out  4  tens digit of last result
//   bcd1    out  4  units digit of last result
//   en100   out  1  hundreds digit enable (non-zero hundreds)
//   en10    out  1  tens digit enable (non-zero hundreds or tens)
//   result  out  7  last result, binary
//   busy    out  1  roll in progress
//   done    out  1  one-cycle pulse in the cycle the outputs update
// ---------------------------------------------------------------------------
module dice_roll_ctrl #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                MAX_TRIES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       roll,
  input  logic [6:0] faces,
  output logic [3:0] bcd100,
  output logic [3:0] bcd10,
  output logic [3:0] bcd1,
  output logic       en100,
  output logic       en10,
  output logic [6:0] result,
  output logic       busy,
  output logic       done
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAW    = 2'd1,
    ST_CONVERT = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  // Clamp the requested face count into the supported 2..100 range.
  function automatic logic [6:0] clamp_faces(input logic [6:0] f);
    logic [6:0] r;
    if (f < 7'd2) begin
      r = 7'd2;
    end else if (f > 7'd100) begin
      r = 7'd100;
    end else begin
      r = f;
    end
    return r;
  endfunction

  // Smallest all-ones mask covering F-1, so every candidate below F is
  // reachable and the rejection rate stays below one half.
  function automatic logic [6:0] mask_for(input logic [6:0] f);
    logic [6:0] fm1;
    logic [6:0] m;
    fm1 = f - 7'd1;
    if (fm1 <= 7'd1) begin
      m = 7'd1;
    end else if (fm1 <= 7'd3) begin
      m = 7'd3;
    end else if (fm1 <= 7'd7) begin
      m = 7'd7;
    end else if (fm1 <= 7'd15) begin
      m = 7'd15;
    end else if (fm1 <= 7'd31) begin
      m = 7'd31;
    end else if (fm1 <= 7'd63) begin
      m = 7'd63;
    end else begin
      m = 7'd127;
    end
    return m;
  endfunction

  // One double-dabble iteration on {bcd[11:0], bin[6:0]}: add 3 to every
  // BCD nibble that is 5 or more, then shift the whole scratch left by one.
  function automatic logic [18:0] dd_step(input logic [18:0] s);
    logic [18:0] a;
    a = s;
    for (int i = 0; i < 3; i++) begin
      if (a[7 + 4*i +: 4] >= 4'd5) begin
        a[7 + 4*i +: 4] = a[7 + 4*i +: 4] + 4'd3;
      end else begin
        a[7 + 4*i +: 4] = a[7 + 4*i +: 4];
      end
    end
    return {a[17:0], 1'b0};
  endfunction

  state_t             state_r;
  state_t             state_s;
  logic [LFSR_W-1:0]  lfsr_r;
  logic               lfsr_fb_s;
  logic               roll_prev_r;
  logic               start_s;
  logic [6:0]         faces_lat_r;
  logic [6:0]         mask_r;
  logic [TRY_W-1:0]   tries_r;
  logic [6:0]         cand_s;
  logic               draw_ok_s;
  logic               last_try_s;
  logic [6:0]         draw_val_s;
  logic [6:0]         val_r;
  logic [18:0]        scratch_r;
  logic [2:0]         iter_r;

  logic               latch_s;
  logic               reject_s;
  logic               load_s;
  logic               step_s;
  logic               commit_s;

  logic [3:0]         bcd100_r;
  logic [3:0]         bcd10_r;
  logic [3:0]         bcd1_r;
  logic               en100_r;
  logic               en10_r;
  logic [6:0]         result_r;
  logic               busy_r;
  logic               done_r;

  // Taps x^16+x^14+x^13+x^11+1 map to bits 15, 13, 12 and 10.
  assign lfsr_fb_s  = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
  // The edge detector runs in every state, so an edge seen while busy is consumed.
  assign start_s    = roll & ~roll_prev_r;
  assign cand_s     = lfsr_r[6:0] & mask_r;
  assign draw_ok_s  = (cand_s < faces_lat_r);
  assign last_try_s = (tries_r == TRY_W'(MAX_TRIES - 1));
  // After too many rejections, fall back to the top face.
  assign draw_val_s = draw_ok_s ? (cand_s + 7'd1) : faces_lat_r;

  // Free-running LFSR and roll edge history.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r      <= SEED;
      roll_prev_r <= 1'b0;
    end else begin
      lfsr_r      <= {lfsr_r[LFSR_W-2:0], lfsr_fb_s};
      roll_prev_r <= roll;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state and datapath strobes.
  always_comb begin
    state_s  = state_r;
    latch_s  = 1'b0;
    reject_s = 1'b0;
    load_s   = 1'b0;
    step_s   = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          latch_s = 1'b1;
          state_s = ST_DRAW;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DRAW: begin
        if (draw_ok_s || last_try_s) begin
          load_s  = 1'b1;
          state_s = ST_CONVERT;
        end else begin
          reject_s = 1'b1;
          state_s  = ST_DRAW;
        end
      end
      ST_CONVERT: begin
        step_s = 1'b1;
        if (iter_r == 3'd6) begin
          state_s = ST_COMMIT;
        end else begin
          state_s = ST_CONVERT;
        end
      end
      ST_COMMIT: begin
        commit_s = 1'b1;
        state_s  = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Roll parameters, draw counter and the double-dabble scratch.
  always_ff @(posedge clk) begin
    if (reset) begin
      faces_lat_r <= 7'd2;
      mask_r      <= 7'd1;
      tries_r     <= '0;
      val_r       <= 7'd0;
      scratch_r   <= 19'd0;
      iter_r      <= 3'd0;
    end else begin
      if (latch_s) begin
        faces_lat_r <= clamp_faces(faces);
        mask_r      <= mask_for(clamp_faces(faces));
        tries_r     <= '0;
      end else if (reject_s) begin
        tries_r <= tries_r + TRY_W'(1);
      end else begin
        tries_r <= tries_r;
      end
      if (load_s) begin
        val_r     <= draw_val_s;
        scratch_r <= {12'd0, draw_val_s};
        iter_r    <= 3'd0;
      end else if (step_s) begin
        scratch_r <= dd_step(scratch_r);
        iter_r    <= iter_r + 3'd1;
      end else begin
        scratch_r <= scratch_r;
        iter_r    <= iter_r;
      end
    end
  end

  // Output registers: all update together in COMMIT and hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd100_r <= 4'd0;
      bcd10_r  <= 4'd0;
      bcd1_r   <= 4'd0;
      en100_r  <= 1'b0;
      en10_r   <= 1'b0;
      result_r <= 7'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= commit_s;
      if (commit_s) begin
        bcd100_r <= scratch_r[18:15];
        bcd10_r  <= scratch_r[14:11];
        bcd1_r   <= scratch_r[10:7];
        en100_r  <= (scratch_r[18:15] != 4'd0);
        en10_r   <= (scratch_r[18:15] != 4'd0) || (scratch_r[14:11] != 4'd0);
        result_r <= val_r;
        busy_r   <= 1'b0;
      end else if (latch_s) begin
        busy_r <= 1'b1;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  assign bcd100 = bcd100_r;
  assign bcd10  = bcd10_r;
  assign bcd1   = bcd1_r;
  assign en100  = en100_r;
  assign en10   = en10_r;
  assign result = result_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dice_roll_ctrl
//   Directed bench for dice_roll_ctrl. A reference LFSR runs alongside the
//   DUT. For every roll, the predicted value and latency come from the
//   rejection-sampling rules applied to that LFSR. The expected digits come
//   from decimal division of the predicted value.
// ---------------------------------------------------------------------------
module tb_dice_roll_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       roll = 1'b0;
  logic [6:0] faces = 7'd6;
  logic [3:0] bcd100;
  logic [3:0] bcd10;
  logic [3:0] bcd1;
  logic       en100;
  logic       en10;
  logic [6:0] result;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] lfsr_m;
  int          hit [0:127];

  dice_roll_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .roll   (roll),
    .faces  (faces),
    .bcd100 (bcd100),
    .bcd10  (bcd10),
    .bcd1   (bcd1),
    .en100  (en100),
    .en10   (en10),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference LFSR, restarted from the seed whenever reset is sampled.
  always @(posedge clk) begin
    if (reset) lfsr_m <= 16'hACE1;
    else       lfsr_m <= lstep(lfsr_m);
  end

  function automatic int clampf(input logic [6:0] f);
    int r;
    r = int'(f);
    if (r < 2) r = 2;
    if (r > 100) r = 100;
    return r;
  endfunction

  // l_now is the LFSR value in the start cycle; the first draw uses the next one.
  function automatic void predict(input logic [15:0] l_now, input logic [6:0] f_in,
                                  output logic [6:0] val, output int lat);
    int f, m, cand, tries;
    logic [15:0] l;
    f = clampf(f_in);
    m = 1;
    while (m < f - 1) m = m * 2 + 1;
    l = lstep(l_now);
    tries = 0;
    lat = -1;
    val = 7'd0;
    while (lat < 0) begin
      cand = int'(l[6:0]) & m;
      if (cand < f) begin
        val = 7'(cand + 1);
        lat = 10 + tries;
      end else begin
        tries++;
        if (tries == 16) begin
          val = 7'(f);
          lat = 9 + tries;
        end else begin
          l = lstep(l);
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start a roll in the current cycle (called at a negedge with roll low and
  // the DUT idle). The task returns at the negedge of the cycle given by the
  // larger of the latency and hold.
  task automatic do_roll(input logic [6:0] fv, input logic [6:0] fmid,
                         input int hold, input bit noise);
    logic [6:0] ev;
    int lat, last, fc;
    int d100, d10, d1;
    faces = fv;
    roll  = 1'b1;
    predict(lfsr_m, fv, ev, lat);
    fc   = clampf(fv);
    d100 = int'(ev) / 100;
    d10  = (int'(ev) / 10) % 10;
    d1   = int'(ev) % 10;
    last = (hold > lat) ? hold : lat;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      if (k == hold) roll = 1'b0;
      if (noise && k >= 2 && k <= 7) roll = ~k[0];
      if (k == 3) faces = fmid;
      chk("busy", 32'(busy), 32'(k < lat));
      chk("done", 32'(done), 32'(k == lat));
      if (k == lat) begin
        chk("result", 32'(result), 32'(ev));
        chk("in_range", 32'(result >= 7'd1 && int'(result) <= fc), 32'd1);
        chk("bcd100", 32'(bcd100), 32'(d100));
        chk("bcd10", 32'(bcd10), 32'(d10));
        chk("bcd1", 32'(bcd1), 32'(d1));
        chk("en100", 32'(en100), 32'(d100 != 0));
        chk("en10", 32'(en10), 32'(d100 != 0 || d10 != 0));
        hit[result]++;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bcd100"}, 32'(bcd100), 32'd0);
    chk({tag, "_bcd10"}, 32'(bcd10), 32'd0);
    chk({tag, "_bcd1"}, 32'(bcd1), 32'd0);
    chk({tag, "_en100"}, 32'(en100), 32'd0);
    chk({tag, "_en10"}, 32'(en10), 32'd0);
    chk({tag, "_result"}, 32'(result), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dones;
    for (int i = 0; i < 128; i++) hit[i] = 0;

    // 1: reset held three cycles, then idle with no roll
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("idle_no_done", 32'(dones), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // 2: d6, single pulse then many rolls with short idle gaps
    do_roll(7'd6, 7'd6, 1, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_roll(7'd6, 7'd6, 1, 1'b0);
    end
    for (int f = 1; f <= 6; f++) chk("d6_face_hit", 32'(hit[f] > 0), 32'd1);

    // 3: d100 against the reference model, including multi-digit results
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_roll(7'd100, 7'd100, 1, 1'b0);
    end

    // 4: roll held high, pulses while busy, restart in first idle cycle
    @(negedge clk);
    do_roll(7'd20, 7'd20, 50, 1'b0);
    @(negedge clk);
    do_roll(7'd20, 7'd20, 1, 1'b1);
    do_roll(7'd20, 7'd20, 1, 1'b0);

    // 5: clamping and faces changed mid-roll
    for (int i = 0; i < 20; i++) begin
      do_roll(7'd0, 7'd0, 1, 1'b0);
      do_roll(7'd1, 7'd1, 1, 1'b0);
      do_roll(7'd127, 7'd127, 1, 1'b0);
      do_roll(7'd6, 7'd100, 1, 1'b0);
      do_roll(7'd100, 7'd3, 1, 1'b0);
    end

    // 6: reset during CONVERT aborts the roll; next roll restarts from seed
    @(negedge clk);
    faces = 7'd100;
    roll  = 1'b1;
    @(negedge clk);
    roll = 1'b0;
    chk("abort_busy_before", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("abort");
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk_zero("abort_hold");
    do_roll(7'd100, 7'd100, 1, 1'b0);
    do_roll(7'd6, 7'd6, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
